uart8_oversampled_receiver: RTL and testbench
=============================================

Name: uart8_oversampled_receiver

Overview:
- Receive end of the 8N1 serial link driven by the team's Uart8 transmitter.
- Runs on the system clock with a clock-enable tick, not a derived clock.
- Samples each bit at mid-bit using a 3-sample majority vote.
- Delivers bytes through a one-entry valid/ready holding register, with framing-error and overrun reporting.
- Sits between the pad-side rx pin and the command/FIFO logic.

Parameters:
- CLOCK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and >= 8.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rstN  in  1  reset, synchronous, active-low.
- en  in  1  receiver enable.
- in  in  1  asynchronous serial line; idles high.
- out  out  8  received byte, LSB received first.
- valid  out  1  out holds an unconsumed byte.
- ready  in  1  consumer accepts the byte when valid && ready.
- busy  out  1  a frame is in progress (state != IDLE).
- frameErr  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because valid was still set.

Behaviour:
- Reset (rstN=0 at a clk edge):
  - State=IDLE; out=0, valid=0, busy=0, frameErr=0, overrun=0.
  - Synchronizer flops=1; tick counter=0; sample counter=0; bit counter=0.
- Tick: DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), integer. Counter counts 0..DIV-1. tick=1 for one clk when the counter = DIV-1, then the counter wraps to 0. DIV=1 means tick every cycle.
- Synchronizer: `in` passes through 2 flops to give `s`. All decisions use `s`.
- Sample counter sc counts 0..OVERSAMPLE-1 on ticks. Vote = majority of s at sc = M-1, M, M+1, where M = OVERSAMPLE/2. The vote resolves at sc = M+1.
- FSM, advancing on tick only:
  - IDLE: s=0 -> START, sc=0.
  - START: at sc=M+1, vote=1 (false start) -> IDLE, no error. Vote=0 -> wait until sc=OVERSAMPLE-1, then DATA, bit=0, sc=0.
  - DATA: at sc=M+1, shift the vote into the shift register (LSB first). At sc=OVERSAMPLE-1, bit++. After bit 7 -> STOP.
  - STOP, resolving at sc=M+1:
    - vote=0 -> frameErr pulse, byte discarded, go to WAIT_HIGH.
    - vote=1 and valid=0 -> out<=shift, valid<=1 on the next clk, go to IDLE.
    - vote=1 and valid=1 -> overrun pulse, out unchanged, go to IDLE.
  - WAIT_HIGH: s=1 -> IDLE. This prevents a break or low line from retriggering.
- Returning to IDLE at the stop mid-bit allows back-to-back frames with a 1-bit stop.
- Handshake:
  - valid clears on the clk edge where valid && ready.
  - If a byte completes on the same edge that the previous byte is consumed, it is not an overrun: out loads the new byte and valid stays 1.
- en=0: FSM forced to IDLE and busy=0 at the next edge; a frame in progress is aborted silently. out/valid are retained and the handshake keeps working. The tick counter keeps running.
- Latency: valid rises 1 clk after the tick at which the stop bit resolves, plus 2 clk synchronizer delay relative to the line.
- Widths: counters sized with $clog2 of DIV, OVERSAMPLE and 8. All comparisons are unsigned.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, timed as one bit.
  - Adds parameter PARITY_ODD, default 0 (0 = even parity).
  - Adds output parityErr, a one-cycle pulse when the voted parity bit mismatches.
  - On a mismatch the byte is discarded (no valid, no overrun); the stop bit is still checked.
- Undefined: 8N1 only. No parityErr port, no PARITY state.

Test Plan:
- All scenarios use CLOCK_RATE=1600, BAUD_RATE=100, OVERSAMPLE=16, so DIV=1 and one bit = 16 clk.
- Clean frame: send 0xA5 8N1 with ready=0 -> valid=1, out=0xA5, frameErr=0. Raise ready -> valid=0 on the next edge.
- Back-to-back with overrun: send 0x3C then 0xC3 with no idle and ready=0 -> out=0x3C, then a single overrun pulse at the second stop resolution, and out still 0x3C.
- Glitch: 4-clk low pulse on in while IDLE -> false start; busy returns to 0, valid=0, no error pulses.
- Framing error: send 0x55 with the stop bit low, holding the line low for 40 clk -> frameErr pulses once, valid=0, busy=1 until the line goes high, then 0. Next frame 0x01 -> out=0x01.
- Noise tolerance: flip in at sample 7 of every data bit while sending 0x96 -> out=0x96.
- Abort and reset: drop en mid-frame (bit 3) -> busy=0 next edge, no valid. Assert rstN=0 while valid=1 -> valid=0, out=0x00 after the edge.

Source files
------------

// File: rtl/uart8_oversampled_receiver.sv
// uart8_oversampled_receiver: 8N1 serial receiver for the Uart8 link.
// It runs on the system clock and advances on a clock-enable tick at
// OVERSAMPLE ticks per bit. Each bit is sampled near mid-bit with a 3-sample
// majority vote. Received bytes are held in a one-entry valid/ready register.
//
// Optional feature: define UART_RX_PARITY_EN to add one parity bit between the
// data bits and the stop bit. This adds the PARITY_ODD parameter and the
// parityErr output.
//
// Ports:
//   clk        system clock, rising edge
//   rstN       synchronous active-low reset
//   en         receiver enable; low aborts any frame in progress
//   in         asynchronous serial line, idles high
//   out[7:0]   received byte, LSB received first
//   valid      out holds an unconsumed byte
//   ready      consumer takes the byte when valid && ready
//   busy       a frame is in progress
//   frameErr   one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed byte dropped, holding register full
//   parityErr  (UART_RX_PARITY_EN only) one-cycle pulse: parity mismatch
module uart8_oversampled_receiver #(
    parameter int unsigned CLOCK_RATE = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16     // even, >= 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0   // 0 = even parity
`endif
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frameErr,
`ifdef UART_RX_PARITY_EN
    output logic       parityErr,
`endif
    output logic       overrun
);

    localparam int unsigned DIV   = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(8);
    localparam int unsigned MID   = OVERSAMPLE / 2;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_VOTE_LO  = SC_W'(MID - 1);
    localparam logic [SC_W-1:0]  SC_VOTE_MID = SC_W'(MID);
    localparam logic [SC_W-1:0]  SC_VOTE_HI  = SC_W'(MID + 1);
    localparam logic [SC_W-1:0]  SC_LAST     = SC_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic             sync_q;
    logic             s;
    logic [SC_W-1:0]  sc;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       shift;
    logic [1:0]       samp;
    logic             vote;
    logic             byte_ok;

    // Oversample tick generator; free-running regardless of en.
    assign tick = (tick_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous line; reset to the idle level.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            sync_q <= 1'b1;
            s      <= 1'b1;
        end else begin
            sync_q <= in;
            s      <= sync_q;
        end
    end

    // Majority of the two stored samples and the live sample at sc = MID+1.
    assign vote = (samp[0] & samp[1]) | (samp[0] & s) | (samp[1] & s);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign byte_ok = !par_bad;
`else
    assign byte_ok = 1'b1;
`endif

    // Receive FSM, sample counters and output holding register.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            sc       <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            samp     <= 2'b11;
            out      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            frameErr <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr <= 1'b0;
`endif
            // Consumer handshake; a byte completing on this edge overrides it.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            if (!en) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                sc    <= '0;
            end else if (tick) begin
                sc <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
                if (sc == SC_VOTE_LO) begin
                    samp[0] <= s;
                end
                if (sc == SC_VOTE_MID) begin
                    samp[1] <= s;
                end

                unique case (state)
                    ST_IDLE: begin
                        if (!s) begin
                            state <= ST_START;
                            sc    <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if ((sc == SC_VOTE_HI) && vote) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (sc == SC_LAST) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (sc == SC_VOTE_HI) begin
                            shift <= {vote, shift[7:1]};
                        end
                        if (sc == SC_LAST) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (sc == SC_VOTE_HI) begin
                            par_bad   <= (vote != ((^shift) ^ PARITY_ODD));
                            parityErr <= (vote != ((^shift) ^ PARITY_ODD));
                        end
                        if (sc == SC_LAST) begin
                            state <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        // Resolve at mid-stop so a back-to-back start edge is caught.
                        if (sc == SC_VOTE_HI) begin
                            if (!vote) begin
                                frameErr <= 1'b1;
                                state    <= ST_WAIT_HIGH;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                if (byte_ok) begin
                                    if (valid && !ready) begin
                                        overrun <= 1'b1;
                                    end else begin
                                        out   <= shift;
                                        valid <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ST_WAIT_HIGH: begin
                        // Hold off until the line returns high so a break cannot retrigger.
                        if (s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart8_oversampled_receiver.sv
// Testbench for uart8_oversampled_receiver: directed scenarios followed by
// randomized frames checked against a byte-level model of the holding register.
module tb_uart8_oversampled_receiver;

    localparam int unsigned CLOCK_RATE = 1600;
    localparam int unsigned BAUD_RATE  = 100;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned BIT_CLKS   = 16;   // DIV = 1
    localparam int unsigned N_RAND     = 24;

    logic       clk   = 1'b0;
    logic       rstN  = 1'b0;
    logic       en    = 1'b0;
    logic       line  = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       frameErr;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    int noise_mode = 0;        // 0 clean, 1 flip clock 8 of each data bit, 2 random flips
    logic [7:0] got_q[$];

    uart8_oversampled_receiver #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .en      (en),
        .in      (line),
        .out     (out),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .frameErr(frameErr),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Pulse counters and consumed-byte log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstN) begin
            if (frameErr) fe_seen++;
            if (overrun) ov_seen++;
            if (valid && ready) got_q.push_back(out);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            line = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            line = 1'b0;
        end
    endtask

    // One bit period; flip >= 0 inverts the line for that single clock.
    // Clocks 8..10 of a bit are the ones the receiver votes on, so at most
    // one of the three votes is ever corrupted.
    task automatic drive_bit(input logic v, input int flip);
        for (int k = 0; k < int'(BIT_CLKS); k++) begin
            @(posedge clk); #1;
            line = (k == flip) ? ~v : v;
        end
    endtask

    function automatic int pick_flip();
        if (noise_mode == 1) return 8;
        if (noise_mode == 2) return ($urandom_range(0, 3) == 0) ? -1 : 7 + int'($urandom_range(1, 3));
        return -1;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_clks);
        drive_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], pick_flip());
        for (int k = 0; k < stop_clks; k++) begin
            @(posedge clk); #1;
            line = stop;
        end
    endtask

    task automatic consume();
        ready = 1'b1;
        idle(2);
        ready = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        logic       model_valid;
        logic [7:0] model_out;
        int         fe_exp;
        int         ov_exp;
        logic       rdy;
        logic       bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frameErr", 32'(frameErr), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rstN = 1'b1;
        en   = 1'b1;
        idle(20);

        // Clean frame, then handshake
        send_frame(8'hA5, 1'b1, 16);
        check("clean_valid", 32'(valid), 32'h1);
        check("clean_out", 32'(out), 32'hA5);
        check("clean_frameErr_cnt", 32'(fe_seen), 32'h0);
        check("clean_busy", 32'(busy), 32'h0);
        idle(3);
        ready = 1'b1;
        idle(1);
        check("clean_consumed_valid", 32'(valid), 32'h0);
        ready = 1'b0;
        check("clean_got_cnt", 32'(got_q.size()), 32'h1);
        if (got_q.size() > 0) check("clean_got_byte", 32'(got_q[0]), 32'hA5);

        // Back-to-back frames with overrun on the second
        ov0 = ov_seen;
        fe0 = fe_seen;
        send_frame(8'h3C, 1'b1, 16);
        check("b2b_first_valid", 32'(valid), 32'h1);
        check("b2b_first_no_ov", 32'(ov_seen - ov0), 32'h0);
        send_frame(8'hC3, 1'b1, 16);
        idle(2);
        check("b2b_overrun_cnt", 32'(ov_seen - ov0), 32'h1);
        check("b2b_out_kept", 32'(out), 32'h3C);
        check("b2b_valid", 32'(valid), 32'h1);
        check("b2b_no_fe", 32'(fe_seen - fe0), 32'h0);
        consume();

        // Glitch: 4-clock low pulse is a false start
        ov0 = ov_seen;
        fe0 = fe_seen;
        hold_low(4);
        idle(1);
        check("glitch_busy_start", 32'(busy), 32'h1);
        idle(24);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_no_fe", 32'(fe_seen - fe0), 32'h0);
        check("glitch_no_ov", 32'(ov_seen - ov0), 32'h0);

        // Framing error with a 40-clock low line, then recovery
        fe0 = fe_seen;
        send_frame(8'h55, 1'b0, 40);
        check("ferr_cnt", 32'(fe_seen - fe0), 32'h1);
        check("ferr_valid", 32'(valid), 32'h0);
        check("ferr_busy_low", 32'(busy), 32'h1);
        idle(6);
        check("ferr_busy_released", 32'(busy), 32'h0);
        send_frame(8'h01, 1'b1, 16);
        idle(2);
        check("ferr_next_out", 32'(out), 32'h01);
        check("ferr_next_valid", 32'(valid), 32'h1);
        check("ferr_single_pulse", 32'(fe_seen - fe0), 32'h1);
        consume();

        // Noise on one voted sample of every data bit
        noise_mode = 1;
        send_frame(8'h96, 1'b1, 16);
        noise_mode = 0;
        idle(2);
        check("noise_out", 32'(out), 32'h96);
        check("noise_valid", 32'(valid), 32'h1);
        consume();

        // Abort mid bit 3 by dropping en
        ov0 = ov_seen;
        fe0 = fe_seen;
        b = 8'h00;
        drive_bit(1'b0, -1);
        for (int i = 0; i < 3; i++) drive_bit(b[i], -1);
        hold_low(8);
        check("abort_busy_before", 32'(busy), 32'h1);
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_after", 32'(busy), 32'h0);
        idle(80);
        en = 1'b1;
        idle(20);
        check("abort_valid", 32'(valid), 32'h0);
        check("abort_busy_idle", 32'(busy), 32'h0);
        check("abort_no_events", 32'((fe_seen - fe0) + (ov_seen - ov0)), 32'h0);

        // Reset while a byte is held
        send_frame(8'h5A, 1'b1, 16);
        idle(2);
        check("prerst_valid", 32'(valid), 32'h1);
        rstN = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_out", 32'(out), 32'h0);
        rstN = 1'b1;
        idle(10);

        // Randomized frames against a holding-register model
        got_q.delete();
        fe0 = fe_seen;
        ov0 = ov_seen;
        model_valid = 1'b0;
        model_out   = 8'h00;
        fe_exp = 0;
        ov_exp = 0;
        noise_mode = 2;
        for (int n = 0; n < int'(N_RAND); n++) begin
            rdy = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 7) == 0);
            b   = 8'($urandom);
            ready = rdy;
            if (rdy && model_valid) begin
                exp_q.push_back(model_out);
                model_valid = 1'b0;
            end
            send_frame(b, !bad, bad ? 16 + int'($urandom_range(0, 20)) : 16);
            if (bad) begin
                fe_exp++;
            end else if (model_valid) begin
                ov_exp++;
            end else if (rdy) begin
                exp_q.push_back(b);
            end else begin
                model_valid = 1'b1;
                model_out   = b;
            end
            if (bad) idle(4 + int'($urandom_range(0, 10)));
            else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 30)));
        end
        noise_mode = 0;
        idle(4);
        ready = 1'b1;
        if (model_valid) exp_q.push_back(model_out);
        idle(4);
        ready = 1'b0;
        check("rand_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("rand_byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("rand_frameErr_cnt", 32'(fe_seen - fe0), 32'(fe_exp));
        check("rand_overrun_cnt", 32'(ov_seen - ov0), 32'(ov_exp));
        check("rand_final_valid", 32'(valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
